counter_mod: RTL and testbench

Parametrised modulo counter, successor to the fixed 8-bit free-running counter. Adds:
- configurable width and modulus
- runtime-selectable direction modes (up, down, bounce, hold)
- synchronous clear, parallel load and count enable
- registered terminal-count pulse

Serves as a reusable timebase and sequencer for board-level labs: dividers, LED scanners and PWM periods.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_mod_if.sv | 35 +++
 rtl/counter_mod.sv | 119 +++++++++++
 tb/tb_counter_mod.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the modulo counter family.
//   mode_e : direction-mode encodings driven onto the counter's mode input.
// Imported by the counter RTL and by benches that drive it.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

endpackage

// File: rtl/counter_mod_if.sv
// counter_mod_if
// Control and status bundle for counter_mod.
//   en    : count enable
//   mode  : direction mode (see counter_pkg::mode_e)
//   clr   : synchronous clear
//   load  : synchronous parallel load of din
//   din   : load value, WIDTH bits
//   q     : registered count
//   dir   : registered direction, 1 = up
//   tc    : registered terminal-count pulse
// master drives the controls and observes status; slave is the counter.
interface counter_mod_if #(
    parameter int WIDTH = 8
);

    logic             en;
    logic [1:0]       mode;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             dir;
    logic             tc;

    modport master (
        output en, mode, clr, load, din,
        input  q, dir, tc
    );

    modport slave (
        input  en, mode, clr, load, din,
        output q, dir, tc
    );

endinterface

// File: rtl/counter_mod.sv
// counter_mod
// Parametrised modulo counter with up, down, bounce and hold modes,
// synchronous clear / saturating load, count enable and a registered
// one-cycle terminal-count pulse. q always stays within 0..MOD_MAX.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : counter_mod_if.slave (en, mode, clr, load, din in; q, dir, tc out)
module counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MOD_MAX = 255,
    parameter int RST_VAL = 0
) (
    input logic          clk,
    input logic          rst,
    counter_mod_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V = '0;

    // Illegal parameter sets stop elaboration instead of producing a
    // counter that could leave its 0..MOD_MAX range.
    if (MOD_MAX < 1 || longint'(MOD_MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_mod_max
        $error("counter_mod: MOD_MAX out of range 1..2^WIDTH-1");
    end
    if (RST_VAL < 0 || RST_VAL > MOD_MAX) begin : g_bad_rst_val
        $error("counter_mod: RST_VAL must lie in 0..MOD_MAX");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;

    // Next-state logic. Priority is clear, then load, then an enabled
    // count step; anything else holds. tc defaults low so it is only a
    // single-cycle pulse marking the wrap or turnaround value.
    // Wraps compare against MOD_MAX explicitly rather than relying on
    // natural overflow, so a modulus below 2^WIDTH-1 works correctly.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;

        if (bus.clr) begin
            count_d = ZERO_V;
        end else if (bus.load) begin
            count_d = (bus.din > MAX_V) ? MAX_V : bus.din;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_UP: begin
                    dir_d = 1'b1;
                    if (count_q == MAX_V) begin
                        count_d = ZERO_V;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + ONE_V;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (count_q == ZERO_V) begin
                        count_d = MAX_V;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - ONE_V;
                    end
                end
                MODE_BOUNCE: begin
                    // Turnaround steps straight to the neighbour of the
                    // endpoint so each endpoint is shown for one cycle.
                    if (dir_q) begin
                        if (count_q == MAX_V) begin
                            count_d = MAX_V - ONE_V;
                            dir_d   = 1'b0;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q + ONE_V;
                        end
                    end else begin
                        if (count_q == ZERO_V) begin
                            count_d = ONE_V;
                            dir_d   = 1'b1;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - ONE_V;
                        end
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State register; reset takes effect immediately and direction
    // restarts upward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_V;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.q   = count_q;
    assign bus.dir = dir_q;
    assign bus.tc  = tc_q;

endmodule

// File: tb/tb_counter_mod.sv
// tb_counter_mod
// Directed bench for counter_mod with WIDTH=8, MOD_MAX=9, RST_VAL=0.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_counter_mod;
    import counter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    counter_mod_if #(.WIDTH(8)) bus ();

    counter_mod #(
        .WIDTH  (8),
        .MOD_MAX(9),
        .RST_VAL(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set every control input in one go.
    task automatic applyStimulus(input logic en, input logic [1:0] mode,
                                 input logic clr, input logic load,
                                 input logic [7:0] din);
        bus.en   = en;
        bus.mode = mode;
        bus.clr  = clr;
        bus.load = load;
        bus.din  = din;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b0, 8'd0);
        #20;
        checks++;
        if ({bus.q, bus.dir, bus.tc} !== {8'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state q=%0d dir=%0b tc=%0b expected q=0 dir=1 tc=0",
                     bus.q, bus.dir, bus.tc);
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_up();
        logic [7:0] expQ;
        logic       expTc;
        for (int i = 1; i <= 10; i++) begin
            tick();
            expQ  = 8'(i % 10);
            expTc = (i == 10);
            checks++;
            if ({bus.q, bus.dir, bus.tc} !== {expQ, 1'b1, expTc}) begin
                failures++;
                $display("[TB] FAIL up_step%0d q=%0d dir=%0b tc=%0b expected q=%0d dir=1 tc=%0b",
                         i, bus.q, bus.dir, bus.tc, expQ, expTc);
            end
        end
    endtask

    task automatic test_down();
        logic [7:0] expQ;
        logic       expTc;
        applyStimulus(1'b1, MODE_DOWN, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            expQ  = 8'((20 - i) % 10);
            expTc = (i == 1) || (i == 11);
            checks++;
            if ({bus.q, bus.dir, bus.tc} !== {expQ, 1'b0, expTc}) begin
                failures++;
                $display("[TB] FAIL down_step%0d q=%0d dir=%0b tc=%0b expected q=%0d dir=0 tc=%0b",
                         i, bus.q, bus.dir, bus.tc, expQ, expTc);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] expQ;
        logic       expDir;
        logic       expTc;
        // Reach q=0 with dir=1: load the top value, then one up wrap.
        applyStimulus(1'b1, MODE_DOWN, 1'b0, 1'b1, 8'd9);
        tick();
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b0, 8'd0);
        tick();
        checks++;
        if ({bus.q, bus.dir, bus.tc} !== {8'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL bounce_setup q=%0d dir=%0b tc=%0b expected q=0 dir=1 tc=1",
                     bus.q, bus.dir, bus.tc);
        end
        applyStimulus(1'b1, MODE_BOUNCE, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i <= 9) begin
                expQ = 8'(i);       expDir = 1'b1; expTc = 1'b0;
            end else if (i <= 18) begin
                expQ = 8'(18 - i);  expDir = 1'b0; expTc = (i == 10);
            end else begin
                expQ = 8'(i - 18);  expDir = 1'b1; expTc = (i == 19);
            end
            checks++;
            if ({bus.q, bus.dir, bus.tc} !== {expQ, expDir, expTc}) begin
                failures++;
                $display("[TB] FAIL bounce_step%0d q=%0d dir=%0b tc=%0b expected q=%0d dir=%0b tc=%0b",
                         i, bus.q, bus.dir, bus.tc, expQ, expDir, expTc);
            end
        end
    endtask

    task automatic test_priority();
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b1, 8'd5);
        tick();
        checks++;
        if (bus.q !== 8'd5) begin
            failures++;
            $display("[TB] FAIL load5 q=%0d expected 5", bus.q);
        end
        applyStimulus(1'b1, MODE_UP, 1'b1, 1'b1, 8'd3);
        tick();
        checks++;
        if ({bus.q, bus.dir, bus.tc} !== {8'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL clr_over_load q=%0d dir=%0b tc=%0b expected q=0 dir=1 tc=0",
                     bus.q, bus.dir, bus.tc);
        end
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b1, 8'd200);
        tick();
        checks++;
        if (bus.q !== 8'd9) begin
            failures++;
            $display("[TB] FAIL load_sat200 q=%0d expected 9", bus.q);
        end
        applyStimulus(1'b0, MODE_UP, 1'b0, 1'b1, 8'd4);
        tick();
        checks++;
        if (bus.q !== 8'd4) begin
            failures++;
            $display("[TB] FAIL load_en0 q=%0d expected 4", bus.q);
        end
        applyStimulus(1'b1, MODE_DOWN, 1'b0, 1'b1, 8'd10);
        tick();
        checks++;
        if ({bus.q, bus.dir, bus.tc} !== {8'd9, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL load_sat10 q=%0d dir=%0b tc=%0b expected q=9 dir=1 tc=0",
                     bus.q, bus.dir, bus.tc);
        end
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b1, 8'd9);
        tick();
        checks++;
        if (bus.q !== 8'd9) begin
            failures++;
            $display("[TB] FAIL load_max q=%0d expected 9", bus.q);
        end
    endtask

    task automatic test_hold();
        logic [7:0] expQ;
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b1, 8'd0);
        tick();
        expQ = 8'd0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2) == 0, MODE_UP, 1'b0, 1'b0, 8'd0);
            tick();
            if ((i % 2) == 0) expQ = expQ + 8'd1;
            checks++;
            if ({bus.q, bus.tc} !== {expQ, 1'b0}) begin
                failures++;
                $display("[TB] FAIL enable_step%0d q=%0d tc=%0b expected q=%0d tc=0",
                         i, bus.q, bus.tc, expQ);
            end
        end
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b1, 8'd9);
        tick();
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b0, 8'd0);
        tick();
        checks++;
        if ({bus.q, bus.tc} !== {8'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL up_wrap q=%0d tc=%0b expected q=0 tc=1", bus.q, bus.tc);
        end
        applyStimulus(1'b1, MODE_HOLD, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.q, bus.dir, bus.tc} !== {8'd0, 1'b1, 1'b0}) begin
                failures++;
                $display("[TB] FAIL hold%0d q=%0d dir=%0b tc=%0b expected q=0 dir=1 tc=0",
                         i, bus.q, bus.dir, bus.tc);
            end
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, MODE_UP, 1'b0, 1'b1, 8'd9);
        tick();
        applyStimulus(1'b1, MODE_BOUNCE, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        checks++;
        if ({bus.q, bus.dir, bus.tc} !== {8'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL pre_reset q=%0d dir=%0b tc=%0b expected q=7 dir=0 tc=0",
                     bus.q, bus.dir, bus.tc);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.q, bus.dir, bus.tc} !== {8'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL async_reset q=%0d dir=%0b tc=%0b expected q=0 dir=1 tc=0",
                     bus.q, bus.dir, bus.tc);
        end
        tick();
        checks++;
        if (bus.q !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_held q=%0d expected 0", bus.q);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({bus.q, bus.dir, bus.tc} !== {8'(i), 1'b1, 1'b0}) begin
                failures++;
                $display("[TB] FAIL resume_step%0d q=%0d dir=%0b tc=%0b expected q=%0d dir=1 tc=0",
                         i, bus.q, bus.dir, bus.tc, i);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_priority();
        test_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
